// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane count,
// core opcodes and the address legality check.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int BYTE_LANES = 4;

  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  // Misaligned or beyond the (2**word_aw)-word window; word_aw + 2 must stay below 32.
  function automatic logic addr_err(input logic [31:0] addr, input int word_aw);
    logic [31:0] hi_mask;
    hi_mask  = ~((32'd1 << (word_aw + 2)) - 32'd1);
    addr_err = (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the LSU side (master) and the data memory (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] rdata_r;

  // Read data only moves on a load, so it stays stable while a response is pending.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BYTE_LANES; b++) begin
          if (be[b]) begin
            mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// commits the access and holds the response until the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_responder_if.slave bus,
  output logic            busy
);

  localparam logic [3:0] LAT_C = 4'(LATENCY);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  dmem_req_t         req_r;
  dmem_req_t         cur_req_s;
  logic              accept_s;
  logic              commit_s;
  logic              done_s;
  logic              cur_err_s;
  logic              arr_en_s;
  logic [DATA_W-1:0] arr_rdata_s;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic              load_ok_r;
  logic              busy_r;

  // Live inputs while idle (a zero-latency commit happens on the accept edge), latched copy afterwards.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_req_s = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
    end else begin
      cur_req_s = req_r;
    end
  end

  assign cur_err_s = addr_err(cur_req_s.addr, ADDR_W);
  assign accept_s  = (state_r == ST_IDLE) && bus.req_valid;
  assign done_s    = (state_r == ST_RESP) && bus.rsp_ready;
  assign arr_en_s  = commit_s && !cur_err_s;

  // Next-state and wait-counter logic; commit_s marks the edge that enters RESP.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LAT_C == 4'd0) begin
            state_nxt_s = ST_RESP;
            commit_s    = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = LAT_C;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_RESP;
          cnt_nxt_s   = 4'd0;
          commit_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // FSM state, wait counter and request capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      req_r   <= '{we: 1'b0, addr: 32'd0, wdata: 32'd0, be: 4'd0};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        req_r <= cur_req_s;
      end
    end
  end

  // Handshake and status flags are registered from the next state so they change with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      load_ok_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      if (commit_s) begin
        rsp_err_r <= cur_err_s;
        load_ok_r <= !cur_req_s.we && !cur_err_s;
      end else if (done_s) begin
        rsp_err_r <= 1'b0;
        load_ok_r <= 1'b0;
      end
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en_s),
    .we    (cur_req_s.we),
    .addr  (cur_req_s.addr[ADDR_W+1:2]),
    .be    (cur_req_s.be),
    .wdata (cur_req_s.wdata),
    .rdata (arr_rdata_s)
  );

  // Stores, errors and idle cycles read back as zero.
  assign bus.rsp_rdata = load_ok_r ? arr_rdata_s : {DATA_W{1'b0}};
  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 3), a transaction-level
// model per instance compared every cycle, plus hand-computed directed expectations.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        req_valid_a [3];
  logic        req_we_a    [3];
  logic [31:0] req_addr_a  [3];
  logic [31:0] req_wdata_a [3];
  logic [3:0]  req_be_a    [3];
  logic        rsp_ready_a [3];
  logic        req_ready_a [3];
  logic        rsp_valid_a [3];
  logic [31:0] rsp_rdata_a [3];
  logic        rsp_err_a   [3];
  logic        busy_a      [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 0 : 3);

    dmem_responder_if bus ();
    logic busy;

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave),
      .busy    (busy)
    );

    assign bus.req_valid  = req_valid_a[g];
    assign bus.req_we     = req_we_a[g];
    assign bus.req_addr   = req_addr_a[g];
    assign bus.req_wdata  = req_wdata_a[g];
    assign bus.req_be     = req_be_a[g];
    assign bus.rsp_ready  = rsp_ready_a[g];
    assign req_ready_a[g] = bus.req_ready;
    assign rsp_valid_a[g] = bus.rsp_valid;
    assign rsp_rdata_a[g] = bus.rsp_rdata;
    assign rsp_err_a[g]   = bus.rsp_err;
    assign busy_a[g]      = busy;

    // Model: one outstanding transaction, committed LAT edges after acceptance.
    bit [31:0] mm [1024];
    bit        pend, done, exp_err, l_we;
    bit [31:0] exp_rd, l_addr, l_wd;
    bit [3:0]  l_be;
    longint    n, cn;

    initial begin
      pend = 0; done = 0; exp_err = 0; exp_rd = 0; n = 0; cn = 0;
      forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
          pend = 0; done = 0; exp_rd = 0; exp_err = 0;
        end else begin
          n++;
          if (pend && done && rsp_ready_a[g]) begin
            pend = 0; done = 0; exp_rd = 0; exp_err = 0;
          end else if (!pend && req_valid_a[g]) begin
            pend = 1; l_we = req_we_a[g]; l_addr = req_addr_a[g];
            l_wd = req_wdata_a[g]; l_be = req_be_a[g]; cn = n + LAT;
          end
          if (pend && !done && n == cn) begin
            done = 1;
            if (l_addr % 4 != 0 || l_addr >= 32'h0000_1000) begin
              exp_err = 1; exp_rd = 0;
            end else if (l_we) begin
              for (int b = 0; b < 4; b++)
                if (l_be[b]) mm[l_addr / 4][8*b +: 8] = l_wd[8*b +: 8];
              exp_err = 0; exp_rd = 0;
            end else begin
              exp_err = 0; exp_rd = mm[l_addr / 4];
            end
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        check($sformatf("i%0d_model_rsp_valid", g), 32'(rsp_valid_a[g]), 32'(done));
        check($sformatf("i%0d_model_req_ready", g), 32'(req_ready_a[g]), 32'(!pend));
        check($sformatf("i%0d_model_busy", g),      32'(busy_a[g]),      32'(pend));
        check($sformatf("i%0d_model_rdata", g),     rsp_rdata_a[g],      exp_rd);
        check($sformatf("i%0d_model_err", g),       32'(rsp_err_a[g]),   32'(exp_err));
      end
    end
  end

  task automatic xact(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output logic err, output int lat);
    int k = 0;
    req_we_a[i] = we; req_addr_a[i] = addr; req_wdata_a[i] = wd; req_be_a[i] = be;
    req_valid_a[i] = 1'b1;
    while (req_ready_a[i] !== 1'b1 && k < 50) begin @(negedge clk); #1; k++; end
    check("accept_timeout", 32'(k >= 50), 32'd0);
    @(negedge clk); #1;
    // Scramble the request after acceptance; the responder must not notice.
    req_valid_a[i] = 1'b0; req_we_a[i] = ~we; req_addr_a[i] = ~addr;
    req_wdata_a[i] = ~wd; req_be_a[i] = ~be;
    lat = 0;
    while (rsp_valid_a[i] !== 1'b1 && lat < 50) begin @(negedge clk); #1; lat++; end
    check("rsp_timeout", 32'(lat >= 50), 32'd0);
    rd  = rsp_rdata_a[i];
    err = rsp_err_a[i];
    if (rsp_ready_a[i]) begin @(negedge clk); #1; end
  endtask

  task automatic run(input string nm, input int i, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    xact(i, we, addr, wd, be, rd, err, lat);
    check({nm, "_rdata"}, rd, exp_rd);
    check({nm, "_err"},   32'(err), 32'(exp_err));
    check({nm, "_lat"},   32'(lat), 32'(lat_of(i)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acc;
    for (int i = 0; i < 3; i++) begin
      req_valid_a[i] = 1'b0; req_we_a[i] = 1'b0; req_addr_a[i] = 32'd0;
      req_wdata_a[i] = 32'd0; req_be_a[i] = 4'd0; rsp_ready_a[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", 32'(req_ready_a[i]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid_a[i]), 32'd0);
      check("rst_rdata",     rsp_rdata_a[i],      32'd0);
      check("rst_err",       32'(rsp_err_a[i]),   32'd0);
      check("rst_busy",      32'(busy_a[i]),      32'd0);
    end

    // LATENCY=2: store/load, byte merge, errors, empty byte-enable
    run("st10",    0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    run("ld10",    0, 1'b0, 32'h0000_0010, 32'd0,         4'h0, 32'hDEAD_BEEF, 1'b0);
    run("st4",     0, 1'b1, 32'h0000_0004, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
    run("st4_be",  0, 1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
    run("ld4",     0, 1'b0, 32'h0000_0004, 32'd0,         4'h0, 32'h11BB_33DD, 1'b0);
    run("ld6_mis", 0, 1'b0, 32'h0000_0006, 32'd0,         4'hF, 32'd0, 1'b1);
    run("st0",     0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
    run("st_oor",  0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'd0, 1'b1);
    run("ld0",     0, 1'b0, 32'h0000_0000, 32'd0,         4'h0, 32'hCAFE_F00D, 1'b0);
    run("st_be0",  0, 1'b1, 32'h0000_0010, 32'd0,         4'h0, 32'd0, 1'b0);
    run("ld10_b",  0, 1'b0, 32'h0000_0010, 32'd0,         4'h0, 32'hDEAD_BEEF, 1'b0);

    // Backpressure: response must hold for 5 cycles with rsp_ready low
    rsp_ready_a[0] = 1'b0;
    req_we_a[0] = 1'b0; req_addr_a[0] = 32'h0000_0010; req_valid_a[0] = 1'b1;
    k = 0;
    while (req_ready_a[0] !== 1'b1 && k < 50) begin @(negedge clk); #1; k++; end
    @(negedge clk); #1;
    req_valid_a[0] = 1'b0;
    k = 0;
    while (rsp_valid_a[0] !== 1'b1 && k < 50) begin @(negedge clk); #1; k++; end
    check("bp_rsp_timeout", 32'(k >= 50), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 32'(rsp_valid_a[0]), 32'd1);
      check("bp_rdata",     rsp_rdata_a[0],      32'hDEAD_BEEF);
      check("bp_err",       32'(rsp_err_a[0]),   32'd0);
      check("bp_req_ready", 32'(req_ready_a[0]), 32'd0);
      check("bp_busy",      32'(busy_a[0]),      32'd1);
      @(negedge clk); #1;
    end
    rsp_ready_a[0] = 1'b1;
    @(negedge clk); #1;
    check("bp_req_ready_after", 32'(req_ready_a[0]), 32'd1);
    check("bp_rsp_valid_after", 32'(rsp_valid_a[0]), 32'd0);

    // LATENCY=0: response the cycle after acceptance, accepts every 2 cycles
    run("z_st20", 1, 1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'hF, 32'd0, 1'b0);
    run("z_ld20", 1, 1'b0, 32'h0000_0020, 32'd0,         4'h0, 32'h0BAD_CAFE, 1'b0);
    req_we_a[1] = 1'b0; req_addr_a[1] = 32'h0000_0020; req_valid_a[1] = 1'b1;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (req_ready_a[1] === 1'b1) acc++;
      @(negedge clk); #1;
    end
    req_valid_a[1] = 1'b0;
    check("z_b2b_accepts", 32'(acc), 32'd4);
    @(negedge clk); #1;

    // LATENCY=3: reset during WAIT drops the store
    run("r_st8", 2, 1'b1, 32'h0000_0008, 32'h0000_0005, 4'hF, 32'd0, 1'b0);
    req_we_a[2] = 1'b1; req_addr_a[2] = 32'h0000_0008; req_wdata_a[2] = 32'hFFFF_FFFF;
    req_be_a[2] = 4'hF; req_valid_a[2] = 1'b1;
    k = 0;
    while (req_ready_a[2] !== 1'b1 && k < 50) begin @(negedge clk); #1; k++; end
    @(negedge clk); #1;
    req_valid_a[2] = 1'b0;
    check("r_busy_before", 32'(busy_a[2]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("r_req_ready", 32'(req_ready_a[2]), 32'd1);
    check("r_rsp_valid", 32'(rsp_valid_a[2]), 32'd0);
    check("r_rdata",     rsp_rdata_a[2],      32'd0);
    check("r_err",       32'(rsp_err_a[2]),   32'd0);
    check("r_busy",      32'(busy_a[2]),      32'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    run("r_ld8", 2, 1'b0, 32'h0000_0008, 32'd0, 4'h0, 32'h0000_0005, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that serves the CPU's load/store port over a valid/ready request channel and a valid/ready response channel.
- Holds a word array with byte-enable writes and a configurable number of wait states.
- Flags misaligned and out-of-range accesses instead of touching the array.
- Sits between the core's LSU-side request interface and the memory array, replacing the core-internal data array.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W words (1K).
- DATA_W, 32, data width; must be 32; byte lanes = 4.
- LATENCY, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit i selects bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state=IDLE, wait counter=0.
- Array contents are not reset.
- Asserting reset_n low mid-transaction aborts it and drives outputs to their reset values at once. A store not yet committed is dropped.
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready=1. On the accept edge E0 (req_valid & req_ready), latch req_we, req_addr, req_wdata and req_be.
  - If LATENCY=0, go to RESP.
  - Otherwise go to WAIT with cnt=LATENCY.
- WAIT: req_ready=0. Each edge: if cnt==1, go to RESP; else cnt = cnt-1.
- Entering RESP commits the access on that edge:
  - Load: rsp_rdata = array[word index].
  - Store: write only the enabled bytes; rsp_rdata = 0.
- Timing: rsp_valid is first high in the cycle after edge E0+LATENCY. The access is committed on that same edge.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready. On the edge with rsp_valid & rsp_ready, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Throughput: at most one transaction per LATENCY+2 cycles. A new request cannot be accepted in the same cycle as the response handshake.
- Word index = req_addr[ADDR_W+1:2].
- Error conditions:
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: any req_addr[31:ADDR_W+2] bit set.
- On error: no array access, rsp_err=1, rsp_rdata=0. Latency is unchanged.
- A store with req_be=0 is acknowledged with rsp_err=0 and leaves memory unchanged.
- Loads ignore req_be and always return the full word.
- Request-side inputs are ignored outside IDLE. Requester changes after acceptance have no effect.
- rsp_ready held high before rsp_valid is legal: the handshake completes in the first RESP cycle.

Decomposition:
- Shared package dmem_pkg holds:
  - State encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Byte-lane count constant 4.
  - Opcode constants for the core's LW/SW (7'b0000011, 7'b0100011), used by the core-side adapter.
- One sub-module, dmem_array: single-port synchronous RAM with DEPTH=2**ADDR_W, 4 byte-enable write lanes and registered read, no reset.
- The FSM, latching and error check stay in dmem_responder.

Test Plan:
- Store then load, LATENCY=2:
  - Store addr=0x10, wdata=0xDEADBEEF, be=4'hF, rsp_ready=1 → rsp_valid high in the cycle after E0+2, rsp_err=0, rsp_rdata=0.
  - Load addr=0x10 → rsp_rdata=0xDEADBEEF.
- Byte-enable merge: array[1]=0x11223344; store addr=0x4, wdata=0xAABBCCDD, be=4'b0101 → load addr=0x4 returns 0x11BB33DD.
- Errors:
  - Load addr=0x6 → rsp_err=1, rsp_rdata=0.
  - Store addr=0x1000 (ADDR_W=10) → rsp_err=1, array unchanged; a load of 0x0 returns its prior value.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid, rsp_rdata and rsp_err stay constant, req_ready=0 and busy=1 throughout. req_ready returns to 1 the cycle after the handshake edge.
- LATENCY=0: load accepted at E0 → rsp_valid in the cycle after E0. Back-to-back requests with req_valid held high are accepted every 2 cycles.
- Reset mid-op: store to 0x8 (prior value 0x5) with LATENCY=3; pulse reset_n low during WAIT → outputs return to reset values immediately. A later load of 0x8 returns 0x5 (store dropped).
